ddr_stat_arbiter: RTL

DDR_STAT_ARBITER -- requirements
Module: ddr_stat_arbiter

---
 rtl/ddr_stat_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ddr_stat_arbiter.sv
// Two-requester round-robin arbiter in front of the sh_ddr stat channel.
// Define DDR_STAT_TIMEOUT_EN to add an ack-wait timeout of TIMEOUT_CYCLES.
module ddr_stat_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_n,
  input  logic        req0_valid,
  input  logic        req0_wr,
  input  logic [7:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_wr,
  input  logic [7:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic        req1_err,
  output logic [7:0]  sh_ddr_stat_addr,
  output logic        sh_ddr_stat_wr,
  output logic        sh_ddr_stat_rd,
  output logic [31:0] sh_ddr_stat_wdata,
  input  logic        ddr_sh_stat_ack,
  input  logic [31:0] ddr_sh_stat_rdata,
  input  logic        ddr_sh_stat_int,
  input  logic        int_clr,
  output logic        stat_int_seen
);
  // state    | meaning
  // IDLE     | no transaction; sample valids and arbitrate
  // ISSUE    | one-cycle rd/wr strobe toward sh_ddr
  // WAIT_ACK | hold addr/wdata until ack (or timeout)
  // DONE     | one-cycle done pulse to the granted requester
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;

  if ((TIMEOUT_CYCLES < 4) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 4..65535");
  end

  state_t      r_state, w_state_nxt;
  logic        r_gnt, r_last, r_wr;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata, r_rdata;
  logic        r_int_seen;
  logic        w_pick, w_start, w_ack, w_finish, w_err;

  // r_last resets to 1 so that req0 wins the first contention
  assign w_pick  = (req0_valid && req1_valid) ? !r_last : req1_valid;
  assign w_start = (r_state == IDLE) && (req0_valid || req1_valid);
  assign w_ack   = (r_state == WAIT_ACK) && ddr_sh_stat_ack;

`ifdef DDR_STAT_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_err;
  logic        w_tmo;

  assign w_tmo    = (r_state == WAIT_ACK) && !ddr_sh_stat_ack && (r_cnt == 16'd0);
  assign w_finish = w_ack || w_tmo;
  assign w_err    = r_err;

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_cnt <= 16'd0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ISSUE)
        r_cnt <= 16'(TIMEOUT_CYCLES - 1);
      else if (r_state == WAIT_ACK)
        r_cnt <= w_finish ? 16'd0 : r_cnt - 16'd1;
      if (w_ack)
        r_err <= 1'b0;
      else if (w_tmo)
        r_err <= 1'b1;
    end
  end
`else
  assign w_finish = w_ack;
  assign w_err    = 1'b0;
`endif

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_state    <= IDLE;
      r_gnt      <= 1'b0;
      r_last     <= 1'b1;
      r_wr       <= 1'b0;
      r_addr     <= 8'h0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_int_seen <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_int_seen <= ddr_sh_stat_int || (r_int_seen && !int_clr);
      if (w_start) begin
        r_gnt   <= w_pick;
        r_last  <= w_pick;
        r_wr    <= w_pick ? req1_wr    : req0_wr;
        r_addr  <= w_pick ? req1_addr  : req0_addr;
        r_wdata <= w_pick ? req1_wdata : req0_wdata;
      end
      if (w_ack)
        r_rdata <= r_wr ? 32'h0 : ddr_sh_stat_rdata;
`ifdef DDR_STAT_TIMEOUT_EN
      else if (w_tmo)
        r_rdata <= 32'hDEAD_BEEF;
`endif
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    sh_ddr_stat_addr  = 8'h0;
    sh_ddr_stat_wdata = 32'h0;
    sh_ddr_stat_wr    = 1'b0;
    sh_ddr_stat_rd    = 1'b0;
    req0_done         = 1'b0;
    req1_done         = 1'b0;
    req0_rdata        = 32'h0;
    req1_rdata        = 32'h0;
    req0_err          = 1'b0;
    req1_err          = 1'b0;
    if (r_state != IDLE) begin
      sh_ddr_stat_addr  = r_addr;
      sh_ddr_stat_wdata = r_wdata;
    end
    unique case (r_state)
      IDLE: if (w_start) w_state_nxt = ISSUE;
      ISSUE: begin
        sh_ddr_stat_wr = r_wr;
        sh_ddr_stat_rd = !r_wr;
        w_state_nxt    = WAIT_ACK;
      end
      WAIT_ACK: if (w_finish) w_state_nxt = DONE;
      DONE: begin
        req0_done   = !r_gnt;
        req1_done   = r_gnt;
        req0_rdata  = r_gnt ? 32'h0 : r_rdata;
        req1_rdata  = r_gnt ? r_rdata : 32'h0;
        req0_err    = !r_gnt && w_err;
        req1_err    = r_gnt && w_err;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign stat_int_seen = r_int_seen;

endmodule
